mips_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. Owns HI/LO.

---
 rtl/mips_muldiv_seq_if.sv | 28 ++
 rtl/mips_muldiv_seq.sv | 173 +++++++++++++++++
 tb/tb_mips_muldiv_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_seq_if.sv
// Pipeline-facing bundle for the HI/LO multiply/divide sequencer.
// The pipeline drives ops and HI/LO reads; the unit returns data and status.
interface mips_muldiv_seq_if #(
  parameter int DATA_W = 32
);
  logic              op_valid;
  logic [2:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              mf_req;
  logic              mf_sel;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, mf_req, mf_sel,
    input  rd_data, busy, stall, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, mf_req, mf_sel,
    output rd_data, busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_seq.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, signs fixed up last.
module mips_muldiv_seq #(
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  mips_muldiv_seq_if.slave  bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*DATA_W-1:0] acc_r;
  logic [DATA_W-1:0]   opnd_r;
  logic                is_div_r;
  logic                div0_r;
  logic                sign_a_r;
  logic                sign_b_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;
  logic                busy_r;
  logic                done_r;

  logic                sa_s;
  logic                sb_s;
  logic [DATA_W-1:0]   abs_a_s;
  logic [DATA_W-1:0]   abs_b_s;
  logic [DATA_W:0]     mul_sum_s;
  logic [2*DATA_W-1:0] mul_next_s;
  logic [DATA_W:0]     div_shift_s;
  logic [DATA_W-1:0]   div_rem_s;
  logic [2*DATA_W-1:0] div_next_s;
  logic [2*DATA_W-1:0] prod_fix_s;
  logic [DATA_W-1:0]   quo_s;
  logic [DATA_W-1:0]   rem_s;
  logic [DATA_W-1:0]   quo_fix_s;
  logic [DATA_W-1:0]   rem_fix_s;

  // Operand magnitudes, one multiply/divide step, and final sign fix-up
  always_comb begin
    sa_s    = bus.op[0] & bus.src_a[DATA_W-1];
    sb_s    = bus.op[0] & bus.src_b[DATA_W-1];
    abs_a_s = sa_s ? (-bus.src_a) : bus.src_a;
    abs_b_s = sb_s ? (-bus.src_b) : bus.src_b;

    // acc holds {partial product, remaining multiplier bits}
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]};
    end
    mul_next_s = {mul_sum_s, acc_r[DATA_W-1:1]};

    // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
    div_shift_s = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
    div_rem_s   = div_shift_s[DATA_W-1:0] - opnd_r;
    if (div_shift_s >= {1'b0, opnd_r}) begin
      div_next_s = {div_rem_s, acc_r[DATA_W-2:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
    end

    quo_s = acc_r[DATA_W-1:0];
    rem_s = acc_r[2*DATA_W-1:DATA_W];
    if (sign_a_r ^ sign_b_r) begin
      prod_fix_s = -acc_r;
      quo_fix_s  = -quo_s;
    end else begin
      prod_fix_s = acc_r;
      quo_fix_s  = quo_s;
    end
    if (sign_a_r) begin
      rem_fix_s = -rem_s;
    end else begin
      rem_fix_s = rem_s;
    end
  end

  // Sequencer FSM, datapath registers and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*DATA_W){1'b0}};
      opnd_r   <= {DATA_W{1'b0}};
      is_div_r <= 1'b0;
      div0_r   <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      hi_r     <= {DATA_W{1'b0}};
      lo_r     <= {DATA_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.op_valid && bus.op[2]) begin
            if (bus.op[1:0] == 2'b00) begin
              hi_r <= bus.src_a;
            end else if (bus.op[1:0] == 2'b01) begin
              lo_r <= bus.src_a;
            end
          end else if (bus.op_valid) begin
            is_div_r <= bus.op[1];
            sign_a_r <= sa_s;
            sign_b_r <= sb_s;
            cnt_r    <= CNT_LAST;
            busy_r   <= 1'b1;
            if (bus.op[1] && (bus.src_b == {DATA_W{1'b0}})) begin
              // Divide by zero keeps the raw dividend for HI
              div0_r  <= 1'b1;
              acc_r   <= {{DATA_W{1'b0}}, bus.src_a};
              state_r <= FIX;
            end else if (bus.op[1]) begin
              div0_r  <= 1'b0;
              acc_r   <= {{DATA_W{1'b0}}, abs_a_s};
              opnd_r  <= abs_b_s;
              state_r <= RUN;
            end else begin
              div0_r  <= 1'b0;
              acc_r   <= {{DATA_W{1'b0}}, abs_b_s};
              opnd_r  <= abs_a_s;
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          acc_r <= is_div_r ? div_next_s : mul_next_s;
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        FIX: begin
          if (div0_r) begin
            hi_r <= acc_r[DATA_W-1:0];
            lo_r <= {DATA_W{1'b1}};
          end else if (is_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            hi_r <= prod_fix_s[2*DATA_W-1:DATA_W];
            lo_r <= prod_fix_s[DATA_W-1:0];
          end
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rd_data = bus.mf_sel ? hi_r : lo_r;
  assign bus.stall   = busy_r & (bus.op_valid | bus.mf_req);
endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Self-checking bench for mips_muldiv_seq: directed cases plus random ops
// compared every cycle against an arithmetic reference model.
module tb_mips_muldiv_seq;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mips_muldiv_seq_if #(.DATA_W(W)) bus();
  mips_muldiv_seq #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} straight from the instruction semantics
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint x64, y64;
    int     x32, y32;
    logic [W-1:0] q, r;
    ref_result = 64'h0;
    case (op)
      3'd0: ref_result = {32'h0, a} * {32'h0, b};
      3'd1: begin
        x64 = $signed(a);
        y64 = $signed(b);
        ref_result = 64'(x64 * y64);
      end
      3'd2: begin
        if (b == 32'h0) ref_result = {a, 32'hFFFF_FFFF};
        else ref_result = {a % b, a / b};
      end
      3'd3: begin
        if (b == 32'h0) ref_result = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = {32'h0, 32'h8000_0000};
        else begin
          x32 = $signed(a);
          y32 = $signed(b);
          q = 32'(x32 / y32);
          r = 32'(x32 % y32);
          ref_result = {r, q};
        end
      end
      default: ref_result = 64'h0;
    endcase
  endfunction

  // Reference model: HI/LO plus the number of busy cycles left for a pending result
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  int           m_left;
  logic         m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0; m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
        end
      end else if (bus.op_valid) begin
        if (bus.op == 3'b100) m_hi <= bus.src_a;
        else if (bus.op == 3'b101) m_lo <= bus.src_a;
        else if (!bus.op[2]) begin
          {p_hi, p_lo} <= ref_result(bus.op, bus.src_a, bus.src_b);
          m_left <= (bus.op[1] && bus.src_b == 32'h0) ? 1 : W + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("busy", bus.busy, m_left > 0);
      chk("done", bus.done, m_done);
      chk("stall", bus.stall, (m_left > 0) && (bus.op_valid || bus.mf_req));
      chk("rd_data", bus.rd_data, bus.mf_sel ? m_hi : m_lo);
    end
  end

  task automatic drive_idle();
    bus.op_valid = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0;
    bus.mf_req = 1'b0; bus.mf_sel = 1'b0;
  endtask

  // Present an op and hold it until accepted; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic rq, input logic sel);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    bus.mf_req = rq; bus.mf_sel = sel;
    #1;
    for (int i = 0; i < 200 && bus.stall; i++) begin
      @(posedge clk); #1;
    end
    chk("accept_timeout", bus.stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.mf_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) break;
    end
    chk("done_timeout", bus.done, 1'b1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'h0;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = 32'($urandom_range(0, 20));
      default: pick = 32'($urandom);
    endcase
  endfunction

  initial begin
    drive_idle();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // MULTU max*max with exact latency
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (32) @(posedge clk);
    #1;
    chk("t1_busy_before", bus.busy, 1'b1);
    chk("t1_done_before", bus.done, 1'b0);
    @(posedge clk); #1;
    chk("t1_hi", bus.hi, 32'hFFFF_FFFE);
    chk("t1_lo", bus.lo, 32'h0000_0001);
    chk("t1_done", bus.done, 1'b1);
    chk("t1_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    chk("t1_done_pulse", bus.done, 1'b0);

    // Signed multiply and divide
    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    wait_done();
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    wait_done();
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done();
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'h0);

    // DIVU by zero: one busy cycle
    issue(3'd2, 32'd100, 32'd0, 1'b0, 1'b0);
    chk("dz_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    chk("dz_busy_drop", bus.busy, 1'b0);
    chk("dz_done", bus.done, 1'b1);
    chk("dz_hi", bus.hi, 32'd100);
    chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
    issue(3'd3, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
    wait_done();
    chk("sdz_hi", bus.hi, 32'hFFFF_FFFB);
    chk("sdz_lo", bus.lo, 32'hFFFF_FFFF);

    // MFLO while a DIVU runs
    issue(3'd2, 32'd20, 32'd3, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bus.mf_req = 1'b1; bus.mf_sel = 1'b0;
    #1;
    chk("mf_stall", bus.stall, 1'b1);
    for (int i = 0; i < 100 && bus.stall; i++) begin
      @(posedge clk); #1;
    end
    chk("mf_stall_drop", bus.stall, 1'b0);
    chk("mf_done", bus.done, 1'b1);
    chk("mf_rd", bus.rd_data, 32'd6);
    chk("mf_hi", bus.hi, 32'd2);
    @(negedge clk);
    bus.mf_req = 1'b0;

    // MTHI idle, then MTLO held off by a busy multiply
    issue(3'd4, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    chk("mthi_busy", bus.busy, 1'b0);
    issue(3'd0, 32'd5, 32'd7, 1'b0, 1'b0);
    bus.op_valid = 1'b1; bus.op = 3'd5; bus.src_a = 32'h0000_AAAA;
    #1;
    chk("mtlo_stall", bus.stall, 1'b1);
    chk("mtlo_held", bus.lo, 32'd6);
    for (int i = 0; i < 100 && bus.stall; i++) begin
      @(posedge clk); #1;
    end
    chk("mtlo_mul_lo", bus.lo, 32'd35);
    chk("mtlo_mul_hi", bus.hi, 32'd0);
    @(posedge clk); #1;
    chk("mtlo_lo", bus.lo, 32'h0000_AAAA);
    @(negedge clk);
    bus.op_valid = 1'b0;

    // Reset mid-MULT, then a clean MULT
    issue(3'd1, 32'h1234_5678, 32'hFFFF_FFFB, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_hi", bus.hi, 32'h0);
    chk("ar_lo", bus.lo, 32'h0);
    chk("ar_busy", bus.busy, 1'b0);
    chk("ar_stall", bus.stall, 1'b0);
    chk("ar_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    wait_done();
    chk("ar_mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("ar_mult_lo", bus.lo, 32'hFFFF_FFEB);

    // Random op mix with random HI/LO reads and gaps
    for (int n = 0; n < 150; n++) begin
      logic [W-1:0] a, b;
      a = pick();
      b = pick();
      issue(3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.mf_req = 1'($urandom_range(0, 1));
        bus.mf_sel = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    bus.mf_req = 1'b0;
    for (int i = 0; i < 100 && bus.busy; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
